torpedo_hit_resolver: RTL and testbench

// - Producer of the per-torpedo `collision` input consumed by each torpedo unit.
// - Watches the per-pixel opaque flags of torpedo, asteroid and ship sprites during the active frame.
// - Latches overlaps into a sticky matrix and resolves them once per frame after vsync.
// - Emits one-cycle hit pulses: to the torpedoes, to the asteroid field, and to the ship/score logic.

---
 rtl/torpedo_hit_resolver.sv | 211 +++++++++++++++++++++
 tb/tb_torpedo_hit_resolver.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/torpedo_hit_resolver.sv
// Collects per-frame torpedo/asteroid/ship overlaps, resolves them after vsync and emits hit pulses.
// Latency: pulses and the score update appear TORPEDOS+1 cycles after the accepted vsync cycle.
// Backpressure: none; every output is a registered one-cycle pulse or level that cannot be stalled.
//
// Ports:
//   clk        system/pixel clock
//   reset      synchronous, active-high
//   vsync      1-cycle frame pulse; snapshots the frame's overlaps and starts resolution
//   pix_valid  current pixel is inside the active area
//   torp_draw  [TORPEDOS]  torpedo i opaque at current pixel
//   ast_draw   [ASTEROIDS] asteroid j opaque at current pixel
//   ship_draw  ship opaque at current pixel
//   torp_hit   [TORPEDOS]  1-cycle pulse, torpedo i destroyed
//   ast_hit    [ASTEROIDS] 1-cycle pulse, asteroid j destroyed
//   ship_hit   1-cycle pulse, ship struck by an asteroid
//   score      [SCORE_W]   saturating asteroid kill count
//   busy       high while resolution/emission is in progress
//
// Optional feature: define SHIP_INVULN_EN to give the ship INVULN_FR frames of immunity after reset
// and after every ship_hit pulse.

module torpedo_hit_resolver #(
  parameter int TORPEDOS  = 2,
  parameter int ASTEROIDS = 8,
  parameter int SCORE_W   = 16,
  parameter int INVULN_FR = 120
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 vsync,
  input  logic                 pix_valid,
  input  logic [TORPEDOS-1:0]  torp_draw,
  input  logic [ASTEROIDS-1:0] ast_draw,
  input  logic                 ship_draw,
  output logic [TORPEDOS-1:0]  torp_hit,
  output logic [ASTEROIDS-1:0] ast_hit,
  output logic                 ship_hit,
  output logic [SCORE_W-1:0]   score,
  output logic                 busy
);

  localparam int IDX_W = (TORPEDOS > 1) ? $clog2(TORPEDOS) : 1;
  localparam logic [IDX_W-1:0] T_LAST = IDX_W'(TORPEDOS - 1);
  localparam logic [IDX_W-1:0] T_ONE  = IDX_W'(1);

  // Unsupported parameter sets show up as g_bad_params in the elaborated hierarchy.
  if (TORPEDOS < 1 || TORPEDOS > 8 || ASTEROIDS < 1 || ASTEROIDS > 16 || INVULN_FR < 0) begin : g_bad_params
  end

  typedef enum logic [1:0] {
    ST_ACCUM   = 2'd0,
    ST_RESOLVE = 2'd1,
    ST_EMIT    = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Live overlap matrix (m_q/s_q) and the snapshot being resolved (ms_q/ss_q).
  logic [TORPEDOS-1:0][ASTEROIDS-1:0] m_q, ms_q, samp;
  logic                               s_q, ss_q, samp_s;
  logic                               snap;
  logic                               ship_en;

  // Resolution state: current torpedo index, asteroids already claimed, torpedoes granted a hit.
  logic [IDX_W-1:0]     t_q, t_d;
  logic [ASTEROIDS-1:0] claim_q, claim_d;
  logic [TORPEDOS-1:0]  ptorp_q, ptorp_d;
  logic [ASTEROIDS-1:0] req, grant;
  logic                 found;
  logic                 emit_load;

  logic [SCORE_W:0]     pop, sum;
  logic [SCORE_W-1:0]   score_sat;

  // This cycle's overlap contribution; invalid pixels contribute nothing.
  always_comb begin
    samp = '0;
    for (int i = 0; i < TORPEDOS; i++) begin
      samp[i] = (pix_valid && torp_draw[i]) ? ast_draw : '0;
    end
    samp_s = pix_valid & ship_draw & (|ast_draw);
  end

  // A vsync outside ACCUM is ignored: no snapshot, no clear, no FSM effect.
  assign snap = vsync && (state_q == ST_ACCUM);

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_ACCUM;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    t_d       = t_q;
    claim_d   = claim_q;
    ptorp_d   = ptorp_q;
    emit_load = 1'b0;
    req       = ms_q[t_q] & ~claim_q;
    grant     = '0;
    found     = 1'b0;

    // Lowest-index free asteroid wins for the current torpedo.
    for (int j = 0; j < ASTEROIDS; j++) begin
      if (req[j] && !found) begin
        grant[j] = 1'b1;
        found    = 1'b1;
      end
    end

    case (state_q)
      ST_ACCUM: begin
        if (vsync) begin
          state_d = ST_RESOLVE;
          t_d     = '0;
          claim_d = '0;
          ptorp_d = '0;
        end
      end
      ST_RESOLVE: begin
        if (found) begin
          ptorp_d[t_q] = 1'b1;
          claim_d      = claim_q | grant;
        end
        // The last torpedo's claim is folded straight into the output registers.
        if (t_q == T_LAST) begin
          state_d   = ST_EMIT;
          emit_load = 1'b1;
        end else begin
          t_d = t_q + T_ONE;
        end
      end
      ST_EMIT: begin
        state_d = ST_ACCUM;
      end
      default: begin
        state_d = ST_ACCUM;
      end
    endcase
  end

  // Score increment is the number of asteroids claimed this frame, clamped at all-ones.
  always_comb begin
    pop = '0;
    for (int j = 0; j < ASTEROIDS; j++) begin
      pop = pop + (SCORE_W + 1)'(claim_d[j]);
    end
    sum       = {1'b0, score} + pop;
    score_sat = sum[SCORE_W] ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      t_q      <= '0;
      claim_q  <= '0;
      ptorp_q  <= '0;
      m_q      <= '0;
      s_q      <= 1'b0;
      ms_q     <= '0;
      ss_q     <= 1'b0;
      torp_hit <= '0;
      ast_hit  <= '0;
      ship_hit <= 1'b0;
      score    <= '0;
      busy     <= 1'b0;
    end else begin
      t_q     <= t_d;
      claim_q <= claim_d;
      ptorp_q <= ptorp_d;

      // The vsync cycle's own sample belongs to the frame being closed.
      if (snap) begin
        ms_q <= m_q | samp;
        ss_q <= (s_q | samp_s) & ship_en;
        m_q  <= '0;
        s_q  <= 1'b0;
      end else begin
        m_q <= m_q | samp;
        s_q <= s_q | samp_s;
      end

      torp_hit <= emit_load ? ptorp_d : '0;
      ast_hit  <= emit_load ? claim_d : '0;
      ship_hit <= emit_load & ss_q;
      if (emit_load) score <= score_sat;
      busy <= (state_d != ST_ACCUM);
    end
  end

`ifdef SHIP_INVULN_EN
  localparam int INV_W = ($clog2(INVULN_FR + 1) > 7) ? $clog2(INVULN_FR + 1) : 7;

  logic [INV_W-1:0] inv_q;

  // Immunity is judged by the counter value at the vsync that closes the frame, so a load of N
  // suppresses the next N frames in full.
  assign ship_en = (inv_q == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      inv_q <= INV_W'(INVULN_FR);
    end else if (emit_load && ss_q) begin
      inv_q <= INV_W'(INVULN_FR);
    end else if (vsync && (inv_q != '0)) begin
      inv_q <= inv_q - INV_W'(1);
    end
  end
`else
  assign ship_en = 1'b1;
`endif

endmodule

// File: tb/tb_torpedo_hit_resolver.sv
module tb_torpedo_hit_resolver;

  localparam int T   = 2;
  localparam int A   = 8;
  localparam int SW  = 4;
  localparam int INV = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          vsync;
  logic          pix_valid;
  logic [T-1:0]  torp_draw;
  logic [A-1:0]  ast_draw;
  logic          ship_draw;
  logic [T-1:0]  torp_hit;
  logic [A-1:0]  ast_hit;
  logic          ship_hit;
  logic [SW-1:0] score;
  logic          busy;

  torpedo_hit_resolver #(
    .TORPEDOS (T),
    .ASTEROIDS(A),
    .SCORE_W  (SW),
    .INVULN_FR(INV)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .vsync    (vsync),
    .pix_valid(pix_valid),
    .torp_draw(torp_draw),
    .ast_draw (ast_draw),
    .ship_draw(ship_draw),
    .torp_hit (torp_hit),
    .ast_hit  (ast_hit),
    .ship_hit (ship_hit),
    .score    (score),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            due;
    logic [T-1:0]  th;
    logic [A-1:0]  ah;
    logic          sh;
    logic [SW-1:0] sc;
  } exp_t;

  exp_t          exp_q[$];
  int            errors  = 0;
  int            checks  = 0;
  int            cyc_cnt = 0;
  bit            mon_en  = 1'b0;
  logic [SW-1:0] exp_score;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Scoreboard: at the due cycle the pulses and score must match the queued entry;
  // in every other cycle no pulse may be present.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (mon_en) begin
      if (exp_q.size() > 0 && exp_q[0].due == cyc_cnt) begin
        e = exp_q.pop_front();
        checks++;
        if (torp_hit !== e.th) begin
          errors++;
          $display("FAIL torp_hit cyc=%0d: got %b, expected %b", cyc_cnt, torp_hit, e.th);
        end
        checks++;
        if (ast_hit !== e.ah) begin
          errors++;
          $display("FAIL ast_hit cyc=%0d: got %h, expected %h", cyc_cnt, ast_hit, e.ah);
        end
        checks++;
        if (ship_hit !== e.sh) begin
          errors++;
          $display("FAIL ship_hit cyc=%0d: got %b, expected %b", cyc_cnt, ship_hit, e.sh);
        end
        checks++;
        if (score !== e.sc) begin
          errors++;
          $display("FAIL score cyc=%0d: got %0d, expected %0d", cyc_cnt, score, e.sc);
        end
      end else begin
        checks++;
        if (torp_hit !== '0 || ast_hit !== '0 || ship_hit !== 1'b0) begin
          errors++;
          $display("FAIL stray_pulse cyc=%0d: got torp=%b ast=%h ship=%b, expected all zero",
                   cyc_cnt, torp_hit, ast_hit, ship_hit);
        end
      end
    end
  end

  function automatic logic [SW-1:0] sat_add(input logic [SW-1:0] a, input int n);
    int s;
    s = int'(a) + n;
    return (s > (1 << SW) - 1) ? {SW{1'b1}} : SW'(s);
  endfunction

  // Greedy claim, torpedo 0 first, each asteroid at most once.
  function automatic void model_claims(input logic [T-1:0][A-1:0] m,
                                       output logic [T-1:0] th, output logic [A-1:0] ah);
    th = '0;
    ah = '0;
    for (int i = 0; i < T; i++) begin
      for (int j = 0; j < A; j++) begin
        if (m[i][j] && !th[i] && !ah[j]) begin
          th[i] = 1'b1;
          ah[j] = 1'b1;
        end
      end
    end
  endfunction

  task automatic drive_pix(input logic pv, input logic [T-1:0] td, input logic [A-1:0] ad,
                           input logic sd);
    pix_valid = pv;
    torp_draw = td;
    ast_draw  = ad;
    ship_draw = sd;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive_pix(1'b0, '0, '0, 1'b0);
  endtask

  // Drives one vsync cycle (with its own pixel sample) and queues the expected emission.
  task automatic send_vsync(input logic [T-1:0] eth, input logic [A-1:0] eah, input logic esh,
                            input logic pv, input logic [T-1:0] td, input logic [A-1:0] ad,
                            input logic sd);
    exp_t e;
    e.due     = cyc_cnt + T + 1;
    e.th      = eth;
    e.ah      = eah;
    e.sh      = esh;
    exp_score = sat_add(exp_score, $countones(eah));
    e.sc      = exp_score;
    exp_q.push_back(e);
    vsync = 1'b1;
    drive_pix(pv, td, ad, sd);
    vsync     = 1'b0;
    pix_valid = 1'b0;
    torp_draw = '0;
    ast_draw  = '0;
    ship_draw = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (torp_hit !== '0) begin errors++; $display("FAIL reset_torp_hit: got %b, expected 0", torp_hit); end
    checks++;
    if (ast_hit !== '0) begin errors++; $display("FAIL reset_ast_hit: got %h, expected 0", ast_hit); end
    checks++;
    if (ship_hit !== 1'b0) begin errors++; $display("FAIL reset_ship_hit: got %b, expected 0", ship_hit); end
    checks++;
    if (score !== '0) begin errors++; $display("FAIL reset_score: got %0d, expected 0", score); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, expected 0", busy); end
    reset = 1'b0;
    idle(2);
    mon_en = 1'b1;
  endtask

  task automatic test_single_hit;
    drive_pix(1'b1, 2'b01, 8'h08, 1'b0);
    idle(2);
    send_vsync(2'b01, 8'h08, 1'b0, 1'b0, '0, '0, 1'b0);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL busy_after_vsync: got %b, expected 1", busy); end
    idle(T + 3);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL busy_after_emit: got %b, expected 0", busy); end
  endtask

  task automatic test_shared_asteroid;
    drive_pix(1'b1, 2'b11, 8'h04, 1'b0);
    send_vsync(2'b01, 8'h04, 1'b0, 1'b0, '0, '0, 1'b0);
    idle(T + 3);
  endtask

  task automatic test_priority;
    drive_pix(1'b1, 2'b01, 8'h22, 1'b0);
    drive_pix(1'b1, 2'b10, 8'h02, 1'b0);
    send_vsync(2'b01, 8'h02, 1'b0, 1'b0, '0, '0, 1'b0);
    idle(T + 3);
  endtask

  task automatic test_pix_valid;
    drive_pix(1'b0, 2'b11, 8'hFF, 1'b1);
    drive_pix(1'b0, 2'b01, 8'h01, 1'b1);
    send_vsync('0, '0, 1'b0, 1'b0, 2'b11, 8'hFF, 1'b1);
    idle(T + 3);
    // Overlap present only on the vsync cycle itself.
    send_vsync(2'b10, 8'h01, 1'b0, 1'b1, 2'b10, 8'h01, 1'b0);
    idle(T + 3);
  endtask

  // Frames run back to back; the next frame's pixels land while the previous one resolves.
  task automatic test_back_to_back;
    logic [T-1:0][A-1:0] m;
    logic [T-1:0]        th, oh;
    logic [A-1:0]        ah, aj;
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < T; i++) m[i] = A'($urandom() & $urandom());
      model_claims(m, th, ah);
      for (int i = 0; i < T; i++) begin
        for (int j = 0; j < A; j++) begin
          if (m[i][j]) begin
            oh = '0; oh[i] = 1'b1;
            aj = '0; aj[j] = 1'b1;
            drive_pix(1'b1, oh, aj, 1'b0);
          end
        end
      end
      drive_pix(1'b0, '1, '1, 1'b1);
      drive_pix(1'b1, '0, '0, 1'b1);
      drive_pix(1'b1, '1, '0, 1'b0);
      drive_pix(1'b0, '1, '1, 1'b0);
      send_vsync(th, ah, 1'b0, 1'b0, '0, '0, 1'b0);
    end
    idle(T + 4);
  endtask

  task automatic test_reset_abort;
    drive_pix(1'b1, 2'b01, 8'h01, 1'b0);
    vsync = 1'b1;
    drive_pix(1'b0, '0, '0, 1'b0);
    vsync = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy_before: got %b, expected 1", busy); end
    reset = 1'b1;
    drive_pix(1'b0, '0, '0, 1'b0);
    reset = 1'b0;
    exp_score = '0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b, expected 0", busy); end
    checks++;
    if (score !== '0) begin errors++; $display("FAIL abort_score: got %0d, expected 0", score); end
    idle(T + 4);
  endtask

  // Must directly follow a reset so the immunity counter starts from its reset load.
  task automatic test_ship;
    logic [3:0] exp_ship;
`ifdef SHIP_INVULN_EN
    exp_ship = 4'b0100;
`else
    exp_ship = 4'b1111;
`endif
    for (int f = 0; f < 4; f++) begin
      drive_pix(1'b1, '0, 8'h10, 1'b1);
      send_vsync('0, '0, exp_ship[f], 1'b0, '0, '0, 1'b0);
      idle(T + 3);
    end
  endtask

  task automatic test_saturation;
    for (int f = 0; f < 9; f++) begin
      drive_pix(1'b1, 2'b11, 8'h03, 1'b0);
      send_vsync(2'b11, 8'h03, 1'b0, 1'b0, '0, '0, 1'b0);
      idle(T + 3);
    end
    checks++;
    if (score !== {SW{1'b1}}) begin
      errors++;
      $display("FAIL score_saturated: got %0d, expected %0d", score, {SW{1'b1}});
    end
  endtask

  task automatic drain;
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 50) begin
      idle(1);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending emissions, expected 0", exp_q.size());
    end
  endtask

  initial begin
    reset     = 1'b1;
    vsync     = 1'b0;
    pix_valid = 1'b0;
    torp_draw = '0;
    ast_draw  = '0;
    ship_draw = 1'b0;
    exp_score = '0;
    test_reset;
    test_single_hit;
    test_shared_asteroid;
    test_priority;
    test_pix_valid;
    test_back_to_back;
    test_reset_abort;
    test_ship;
    test_saturation;
    drain;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
